// File: rtl/jpeg_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_bit_packer
// Purpose  : Packs 1-16 bit codes MSB-first into bytes, pads with 1s on flush;
//            0x00 is stuffed after every 0xFF when JPEG_BYTE_STUFF_EN is defined.
// Revision : 1.0
// ============================================================================
module jpeg_bit_packer #(
    parameter int CODE_W = 16,
    parameter int LEN_W  = 5,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_stuffed,
    output logic              flush_done
);

`ifdef JPEG_BYTE_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_base, code_msb;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             stuff_pend_q, stuff_pend_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_stuffed_q, out_stuffed_d;
    logic             flush_done_q, flush_done_d;
    logic [7:0]       top_byte, pad_byte;
    logic [LEN_W-1:0] len_c, lsh;
    logic             in_fire, load_slot, drained;

    always_comb begin
        in_ready  = !rst && (state_q == ST_RUN) && (cnt_q <= CNT_W'(CODE_W));
        in_fire   = in_valid && in_ready;
        load_slot = !out_valid_q || out_ready;
        len_c     = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
        lsh       = LEN_W'(CODE_W) - len_c;
        // Shifting the code to the top pushes any bits above in_len off the end.
        code_msb  = {in_code, {(ACC_W-CODE_W){1'b0}}} << lsh;
        top_byte  = acc_q[ACC_W-1 -: 8];
        pad_byte  = top_byte | (8'hFF >> cnt_q[2:0]);

        acc_base      = acc_q;
        cnt_base      = cnt_q;
        out_valid_d   = out_valid_q;
        out_byte_d    = out_byte_q;
        out_stuffed_d = out_stuffed_q;
        stuff_pend_d  = stuff_pend_q;
        state_d       = state_q;
        flush_done_d  = 1'b0;

        if (load_slot) begin
            out_valid_d   = 1'b0;
            out_stuffed_d = 1'b0;
            if (stuff_pend_q) begin
                out_valid_d   = 1'b1;
                out_byte_d    = 8'h00;
                out_stuffed_d = 1'b1;
                stuff_pend_d  = 1'b0;
            end else if (cnt_q >= CNT_W'(8)) begin
                out_valid_d  = 1'b1;
                out_byte_d   = top_byte;
                stuff_pend_d = STUFF_EN && (top_byte == 8'hFF);
                acc_base     = acc_q << 8;
                cnt_base     = cnt_q - CNT_W'(8);
            end else if ((state_q == ST_FLUSH) && (cnt_q != '0)) begin
                out_valid_d  = 1'b1;
                out_byte_d   = pad_byte;
                stuff_pend_d = STUFF_EN && (pad_byte == 8'hFF);
                acc_base     = '0;
                cnt_base     = '0;
            end
        end

        // Append below whatever survives this cycle's extraction.
        acc_d = acc_base;
        cnt_d = cnt_base;
        if (in_fire) begin
            acc_d = acc_base | (code_msb >> cnt_base);
            cnt_d = cnt_base + CNT_W'(len_c);
        end

        drained = (cnt_d == '0) && !stuff_pend_d && !out_valid_d;
        case (state_q)
            ST_RUN: begin
                if (in_fire && in_flush) begin
                    state_d      = drained ? ST_DONE : ST_FLUSH;
                    flush_done_d = drained;
                end
            end
            ST_FLUSH: begin
                if (drained) begin
                    state_d      = ST_DONE;
                    flush_done_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            acc_q         <= '0;
            cnt_q         <= '0;
            stuff_pend_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_byte_q    <= 8'h00;
            out_stuffed_q <= 1'b0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            stuff_pend_q  <= stuff_pend_d;
            out_valid_q   <= out_valid_d;
            out_byte_q    <= out_byte_d;
            out_stuffed_q <= out_stuffed_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_stuffed = out_stuffed_q;
    assign flush_done  = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_bit_packer
// Purpose  : Vector table, directed timing sequences and random traffic
//            against a bit-queue model of jpeg_bit_packer.
// Revision : 1.0
// ============================================================================
module tb_jpeg_bit_packer;

`ifdef JPEG_BYTE_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_flush = 1'b0, out_ready = 1'b0;
    logic [15:0] in_code = '0;
    logic [4:0]  in_len = '0;
    logic        in_ready, out_valid, out_stuffed, flush_done;
    logic [7:0]  out_byte;

    jpeg_bit_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len), .in_flush(in_flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_stuffed(out_stuffed), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, fd_cnt = 0, exp_fd = 0, rdy_mode = 0;
    bit         bits_q[$];
    logic [8:0] exp_q[$], got_q[$];
    logic       hold = 1'b0;
    logic [8:0] hold_v = '0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    function automatic void emit(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        if (STUFF && b == 8'hFF) exp_q.push_back(9'h100);
    endfunction

    // Reference: a plain bit FIFO; a flush pads the tail byte with 1s.
    function automatic void model_push(input logic [15:0] code, input logic [4:0] len, input logic fl);
        int n;
        logic [7:0] b;
        n = (len > 5'd16) ? 16 : int'(len);
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(code[i]);
        while (bits_q.size() >= 8 || (fl && bits_q.size() > 0)) begin
            b = 8'hFF;
            for (int i = 7; i >= 0; i--) if (bits_q.size() > 0) b[i] = bits_q.pop_front();
            emit(b);
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] code, input logic [4:0] len, input logic fl);
        int w;
        w = 0;
        in_valid = 1'b1; in_code = code; in_len = len; in_flush = fl;
        @(negedge clk);
        while (!in_ready && w < 500) begin
            w++;
            @(negedge clk);
        end
        chk("send_accept", in_ready, 1);
        if (in_ready) begin
            model_push(code, len, fl);
            if (fl) exp_fd++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_flush = 1'b0;
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: collects handshaken bytes, counts flush pulses, checks hold.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_byte", {out_stuffed, out_byte}, hold_v);
            end
            if (out_valid && out_ready) got_q.push_back({out_stuffed, out_byte});
            if (flush_done) fd_cnt++;
            hold   = out_valid && !out_ready;
            hold_v = {out_stuffed, out_byte};
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
        logic        flush;
        logic [2:0]  n;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [8:0] eq[$];
        logic [7:0] b;
        logic hs, done;
        int   m;

        vecs[0]  = '{16'h0041, 5'd8,  1'b0, 3'd1, 32'h41000000};
        vecs[1]  = '{16'h000A, 5'd4,  1'b0, 3'd0, 32'h00000000};
        vecs[2]  = '{16'h0005, 5'd4,  1'b0, 3'd1, 32'hA5000000};
        vecs[3]  = '{16'h0003, 5'd2,  1'b0, 3'd0, 32'h00000000};
        vecs[4]  = '{16'h003F, 5'd6,  1'b0, 3'd1, 32'hFF000000};
        vecs[5]  = '{16'h0000, 5'd0,  1'b0, 3'd0, 32'h00000000};
        vecs[6]  = '{16'hBEEF, 5'd20, 1'b0, 3'd2, 32'hBEEF0000};
        vecs[7]  = '{16'hFFF1, 5'd4,  1'b0, 3'd0, 32'h00000000};
        vecs[8]  = '{16'h0000, 5'd0,  1'b1, 3'd1, 32'h1F000000};
        vecs[9]  = '{16'h0005, 5'd3,  1'b1, 3'd1, 32'hBF000000};
        vecs[10] = '{16'h0000, 5'd0,  1'b1, 3'd0, 32'h00000000};
        vecs[11] = '{16'h07FF, 5'd11, 1'b1, 3'd2, 32'hFFFF0000};
        vecs[12] = '{16'hABCD, 5'd16, 1'b0, 3'd2, 32'hABCD0000};
        vecs[13] = '{16'h0000, 5'd0,  1'b1, 3'd0, 32'h00000000};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_stuffed", out_stuffed, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Latency of a full byte
        rdy_mode = 1;
        idle(2);
        in_valid = 1'b1; in_code = 16'h0041; in_len = 5'd8; in_flush = 1'b0;
        chk("lat_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_t0_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", out_valid, 1);
        chk("lat_byte", out_byte, 8'h41);
        idle(3);
        chk("lat_drained", out_valid, 0);

        // Backpressure: 0x1234 then 0x5678 with out_ready low
        rdy_mode = 0;
        idle(2);
        got_q.delete();
        in_valid = 1'b1; in_code = 16'h1234; in_len = 5'd16;
        @(posedge clk); #1;
        chk("bp_ready_after_first", in_ready, 1);
        in_code = 16'h5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_ready_dropped", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_byte", out_byte, 8'h12);
        idle(3);
        chk("bp_byte_held", out_byte, 8'h12);
        chk("bp_ready_still_low", in_ready, 0);
        rdy_mode = 1;
        idle(8);
        chk("bp_count", got_q.size(), 4);
        eq.delete();
        eq.push_back(9'h012); eq.push_back(9'h034); eq.push_back(9'h056); eq.push_back(9'h078);
        m = (got_q.size() < 4) ? got_q.size() : 4;
        for (int i = 0; i < m; i++) chk($sformatf("bp_stream[%0d]", i), got_q[i], eq[i]);

        // Vector table
        for (int v = 0; v < NV; v++) begin
            got_q.delete(); fd_cnt = 0; eq.delete();
            send(vecs[v].code, vecs[v].len, vecs[v].flush);
            idle(8);
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                b = vecs[v].exp[31-8*i -: 8];
                eq.push_back({1'b0, b});
                if (STUFF && b == 8'hFF) eq.push_back(9'h100);
            end
            chk($sformatf("vec%0d_count", v), got_q.size(), eq.size());
            m = (got_q.size() < eq.size()) ? got_q.size() : eq.size();
            for (int i = 0; i < m; i++) chk($sformatf("vec%0d_byte[%0d]", v, i), got_q[i], eq[i]);
            chk($sformatf("vec%0d_flush_done", v), fd_cnt, vecs[v].flush ? 1 : 0);
        end

        // Flush timing: 0b101 with flush
        got_q.delete();
        in_valid = 1'b1; in_code = 16'h0005; in_len = 5'd3; in_flush = 1'b1;
        chk("fl_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_flush = 1'b0;
        hs = 1'b0; done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            if (hs) begin
                chk("fl_done_pulse", flush_done, 1);
                done = 1'b1;
            end else begin
                chk("fl_done_early", flush_done, 0);
                chk("fl_ready_low", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                chk("fl_byte", out_byte, 8'hBF);
                hs = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("fl_seen", done, 1);
        chk("fl_done_one_cycle", flush_done, 0);
        chk("fl_ready_back", in_ready, 1);

        // Reset with a byte held and 5 bits pending
        rdy_mode = 0;
        idle(2);
        send(16'h0041, 5'd8, 1'b0);
        send(16'h001F, 5'd5, 1'b0);
        chk("mr_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_byte", out_byte, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_flush_done", flush_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bits_q.delete(); exp_q.delete(); got_q.delete(); fd_cnt = 0; exp_fd = 0;
        rdy_mode = 1;
        send(16'h0041, 5'd8, 1'b0);
        send(16'h0000, 5'd0, 1'b1);
        idle(8);
        chk("mr_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("mr_byte", got_q[0], 9'h041);
        chk("mr_flush_done", fd_cnt, 1);

        // Random traffic against the bit-queue model
        bits_q.delete(); exp_q.delete(); got_q.delete(); fd_cnt = 0; exp_fd = 0;
        rdy_mode = 2;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 7)
                send(16'($urandom), 5'($urandom_range(0, 20)), ($urandom_range(0, 24) == 0));
            else
                idle(1);
        end
        send(16'h0000, 5'd0, 1'b1);
        rdy_mode = 1;
        for (int k = 0; k < 500 && (fd_cnt < exp_fd); k++) idle(1);
        chk("rnd_flush_done", fd_cnt, exp_fd);
        chk("rnd_count", got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("rnd_byte[%0d]", i), got_q[i], exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
